alu_control_muldiv: RTL and testbench
=====================================

// Module: alu_control_muldiv
// PURPOSE
// - Next-generation ALU control for the EX stage.
// - Decodes ALUOp/Function into ALUCtrl (same base encodings as today).
// - Adds a parametrised iterative multiply/divide sequencer with HI/LO registers.
// - Adds a stall handshake to the hazard unit and mfhi/mflo read-out; sits between
//   the main decoder and the ALU/datapath mux.
// PARAMETERS
// - WIDTH      32  operand, HI and LO width; even, >=4
// - CTRL_W     4   ALUCtrl width
// PORTS
// - clk        in   1        clock, all state rises on posedge
// - reset      in   1        asynchronous, active-high; clears all state
// - Valid      in   1        instruction in EX is real (not a bubble)
// - ALUOp      in   2        from main decoder
// - Function   in   6        instr[5:0]
// - SrcA       in   WIDTH    rs operand (dividend / multiplicand)
// - SrcB       in   WIDTH    rt operand (divisor / multiplier)
// - ALUCtrl    out  CTRL_W   ALU operation select, combinational
// - Stall      out  1        hold IF/ID/EX, combinational
// - HiLoRead   out  1        EX result must come from HiLoData (mfhi/mflo)
// - HiLoData   out  WIDTH    HI for mfhi, LO for mflo, else 0
// - Busy       out  1        sequencer not IDLE, registered
// BEHAVIOUR
// - Decode:
//   - ALUOp 00 -> 0010; 01 -> 0110; 11 -> 0000.
//   - ALUOp 10, Function: 100000 add 0010; 100010 sub 0110; 100100 and 0000;
//     100101 or 0001; 101010 slt 1111.
//   - Any other Function -> 0000 (includes mult/div/mfhi/mflo).
// - Muldiv ops (ALUOp=10):
//   - 011000 mult; 011001 multu; 011010 div; 011011 divu.
//   - 010000 mfhi; 010010 mflo -> HiLoRead=1 while Valid.
// - FSM states IDLE -> RUN -> FIX -> IDLE.
// - IDLE: Valid & muldiv op -> latch |operands| (signed) or raw (unsigned), sign
//   flags and op type; count=0; go to RUN. No stall in the launch cycle.
// - RUN: one shift-add (mult) or restoring-subtract (div) step per cycle.
//   After WIDTH steps, go to FIX.
// - FIX: apply sign correction, write HI/LO, go to IDLE.
// - Latency: launch at cycle 0; HI/LO valid from cycle WIDTH+2; Busy=1 in cycles 1..WIDTH+1.
// - Stall = Busy & Valid & (muldiv op | mfhi | mflo). Other instructions flow
//   while Busy; the sequencer does not hold the pipeline for them.
// - A muldiv op arriving while Busy stalls and launches in the first IDLE cycle.
// - mult/multu: {HI,LO} = 2*WIDTH-bit product (signed or unsigned).
// - div/divu: LO = quotient truncated toward zero; HI = remainder with the dividend's sign.
// - Divide by zero: LO = all ones, HI = dividend; full latency still applies.
// - Signed MIN / -1: LO = MIN, HI = 0.
// - Counter width $clog2(WIDTH+1); no wrap (it stops at WIDTH).
// - Reset (any time, including mid-RUN): state IDLE, HI=LO=0, Busy=0, op aborted.
// - Reset values of outputs: Busy=0, Stall=0, HiLoData=0. ALUCtrl and HiLoRead
//   follow their inputs.
// - Valid=0: ALUCtrl is still decoded; HiLoRead=0, Stall=0, no launch.
// CONFIGURATION
// - ALUCTRL_EXT_OPS_EN defined: ALUOp 10 also decodes 100111 nor 1100,
//   100110 xor 0011, 101011 sltu 0111.
// - Undefined: those Functions decode to 0000 like any unknown code; there is
//   no other difference.
// TESTING (WIDTH=32)
// - Decode sweep: ALUOp 00/01 and every listed Function -> exact codes above;
//   Function 111111 -> 0000.
// - mult SrcA=-3, SrcB=7 -> HI=FFFFFFFF, LO=FFFFFFEB at cycle 34; Busy high 33 cycles.
// - divu 100/7 -> LO=14, HI=2. div -7/2 -> LO=FFFFFFFD, HI=FFFFFFFF.
//   div by 0 (SrcA=5) -> LO=FFFFFFFF, HI=5.
// - mflo issued 1 cycle after mult launch -> Stall=1 for 33 cycles, then
//   HiLoRead=1 with the product; an add in between passes with Stall=0.
// - reset pulsed at RUN step 10 -> Busy=0, HI=LO=0 immediately;
//   a new multu 2*3 afterwards -> LO=6.
// - Build with ALUCTRL_EXT_OPS_EN: Function 100111 -> 1100; without it -> 0000.

Source files
------------

// File: rtl/alu_control_muldiv.sv
// EX-stage ALU control with an iterative multiply/divide sequencer.
// Decodes ALUOp/Function into ALUCtrl, runs mult/multu/div/divu one bit per
// cycle into HI/LO, serves mfhi/mflo and stalls the pipeline while a
// muldiv result is still being produced.
// Optional: define ALUCTRL_EXT_OPS_EN to decode nor/xor/sltu.
module alu_control_muldiv #(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              Valid,
  input  logic [1:0]        ALUOp,
  input  logic [5:0]        Function,
  input  logic [WIDTH-1:0]  SrcA,
  input  logic [WIDTH-1:0]  SrcB,
  output logic [CTRL_W-1:0] ALUCtrl,
  output logic              Stall,
  output logic              HiLoRead,
  output logic [WIDTH-1:0]  HiLoData,
  output logic              Busy
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t             state;
  logic [CW-1:0]      count;
  logic [WIDTH-1:0]   hi, lo;
  logic [WIDTH-1:0]   a_reg;   // multiplicand or divisor magnitude
  logic [WIDTH-1:0]   q;       // multiplier / dividend, becomes product low / quotient
  logic [WIDTH-1:0]   rem;     // product high / partial remainder
  logic               is_div, neg_q, neg_r, divzero, busy;

  logic               rtype, muldiv_op, op_mfhi, op_mflo;
  logic               op_signed, neg_a, neg_b;
  logic [WIDTH-1:0]   abs_a, abs_b;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic               div_ge;
  logic [WIDTH-1:0]   div_diff;
  logic [WIDTH-1:0]   rem_nxt, q_nxt;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign rtype     = (ALUOp == 2'b10);
  assign muldiv_op = rtype && (Function[5:2] == 4'b0110);
  assign op_mfhi   = rtype && (Function == 6'b010000);
  assign op_mflo   = rtype && (Function == 6'b010010);
  assign op_signed = ~Function[0];
  assign neg_a     = op_signed & SrcA[WIDTH-1];
  assign neg_b     = op_signed & SrcB[WIDTH-1];
  assign abs_a     = neg_a ? -SrcA : SrcA;
  assign abs_b     = neg_b ? -SrcB : SrcB;

  // ALU operation decode, independent of Valid
  always_comb begin
    ALUCtrl = '0;
    case (ALUOp)
      2'b00: ALUCtrl = CTRL_W'(4'b0010);
      2'b01: ALUCtrl = CTRL_W'(4'b0110);
      2'b10: begin
        case (Function)
          6'b100000: ALUCtrl = CTRL_W'(4'b0010);
          6'b100010: ALUCtrl = CTRL_W'(4'b0110);
          6'b100100: ALUCtrl = CTRL_W'(4'b0000);
          6'b100101: ALUCtrl = CTRL_W'(4'b0001);
          6'b101010: ALUCtrl = CTRL_W'(4'b1111);
`ifdef ALUCTRL_EXT_OPS_EN
          6'b100111: ALUCtrl = CTRL_W'(4'b1100);
          6'b100110: ALUCtrl = CTRL_W'(4'b0011);
          6'b101011: ALUCtrl = CTRL_W'(4'b0111);
`endif
          default:   ALUCtrl = '0;
        endcase
      end
      default: ALUCtrl = '0;
    endcase
  end

  // HI/LO read-out and hazard handshake
  always_comb begin
    HiLoRead = Valid & (op_mfhi | op_mflo);
    Stall    = busy & Valid & (muldiv_op | op_mfhi | op_mflo);
    HiLoData = '0;
    if (Valid && op_mfhi)      HiLoData = hi;
    else if (Valid && op_mflo) HiLoData = lo;
  end

  // One shift-add or restoring-subtract step; the divide compare uses the
  // full WIDTH+1 shifted value so the low WIDTH bits of the difference are exact
  always_comb begin
    mul_sum   = {1'b0, rem} + {1'b0, (q[0] ? a_reg : '0)};
    div_shift = {rem, q[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, a_reg});
    div_diff  = div_shift[WIDTH-1:0] - a_reg;
    if (is_div) begin
      rem_nxt = div_ge ? div_diff : div_shift[WIDTH-1:0];
      q_nxt   = {q[WIDTH-2:0], div_ge};
    end else begin
      rem_nxt = mul_sum[WIDTH:1];
      q_nxt   = {mul_sum[0], q[WIDTH-1:1]};
    end
  end

  // Sign correction of the finished magnitudes
  always_comb begin
    prod     = {rem, q};
    prod_fix = neg_q ? -prod : prod;
    quo_fix  = divzero ? '1 : (neg_q ? -q : q);
    rem_fix  = neg_r ? -rem : rem;
  end

  // Sequencer FSM with HI/LO and registered Busy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      count   <= '0;
      hi      <= '0;
      lo      <= '0;
      a_reg   <= '0;
      q       <= '0;
      rem     <= '0;
      is_div  <= 1'b0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      divzero <= 1'b0;
      busy    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (Valid && muldiv_op) begin
            is_div  <= Function[1];
            neg_q   <= neg_a ^ neg_b;
            neg_r   <= neg_a;
            divzero <= Function[1] && (SrcB == '0);
            a_reg   <= Function[1] ? abs_b : abs_a;
            q       <= Function[1] ? abs_a : abs_b;
            rem     <= '0;
            count   <= '0;
            busy    <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          rem   <= rem_nxt;
          q     <= q_nxt;
          count <= count + 1'b1;
          if (count == LAST) state <= FIX;
        end
        FIX: begin
          if (is_div) begin
            hi <= rem_fix;
            lo <= quo_fix;
          end else begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign Busy = busy;

endmodule

// File: tb/tb_alu_control_muldiv.sv
// Scoreboard bench for alu_control_muldiv (WIDTH=32).
module tb_alu_control_muldiv;

  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;
`ifdef ALUCTRL_EXT_OPS_EN
  localparam bit EXT = 1'b1;
`else
  localparam bit EXT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        Valid;
  logic [1:0]  ALUOp;
  logic [5:0]  Function;
  logic [31:0] SrcA, SrcB;
  logic [3:0]  ALUCtrl;
  logic        Stall, HiLoRead, Busy;
  logic [31:0] HiLoData;

  alu_control_muldiv #(.WIDTH(32), .CTRL_W(4)) dut (
    .clk(clk), .reset(reset), .Valid(Valid), .ALUOp(ALUOp), .Function(Function),
    .SrcA(SrcA), .SrcB(SrcB), .ALUCtrl(ALUCtrl), .Stall(Stall),
    .HiLoRead(HiLoRead), .HiLoData(HiLoData), .Busy(Busy)
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  typedef struct {
    string       tag;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;
  exp_t sb[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [5:0] fn,
                       input logic [31:0] a, input logic [31:0] b);
    Valid = v; ALUOp = op; Function = fn; SrcA = a; SrcB = b;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  function automatic logic [63:0] model(input logic [5:0] fn, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sbv, qq, rr;
    logic [63:0] r;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    r   = '0;
    case (fn)
      F_MULT:  r = 64'(sa * sbv);
      F_MULTU: r = {32'b0, a} * {32'b0, b};
      F_DIV: begin
        if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
        else begin
          qq = sa / sbv; rr = sa % sbv;
          r = {rr[31:0], qq[31:0]};
        end
      end
      default: begin
        if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
        else r = {a % b, a / b};
      end
    endcase
    return r;
  endfunction

  // Drive a muldiv op, wait out any stall, let it launch; returns in cycle 1.
  task automatic issue(input string tag, input logic [5:0] fn, input logic [31:0] a,
                       input logic [31:0] b, input bit push, output int stalls);
    logic [63:0] m;
    exp_t e;
    stalls = 0;
    drive(1'b1, 2'b10, fn, a, b);
    #1;
    while (Stall && stalls < 100) begin
      stalls++;
      step();
    end
    if (stalls >= 100) check({tag, "_launch_timeout"}, 64'd1, 64'd0);
    if (push) begin
      m = model(fn, a, b);
      e.tag = tag; e.hi = m[63:32]; e.lo = m[31:0];
      sb.push_back(e);
    end
    step();
    drive(1'b0, 2'b00, 6'd0, 32'd0, 32'd0);
  endtask

  task automatic read_hilo(input string tag, output logic [31:0] hi, output logic [31:0] lo);
    int n;
    n = 0;
    drive(1'b1, 2'b10, F_MFHI, 32'd0, 32'd0);
    #1;
    while (Stall && n < 100) begin
      n++;
      step();
    end
    if (n >= 100) check({tag, "_read_timeout"}, 64'd1, 64'd0);
    check({tag, "_hilord"}, 64'(HiLoRead), 64'd1);
    hi = HiLoData;
    drive(1'b1, 2'b10, F_MFLO, 32'd0, 32'd0);
    #1;
    lo = HiLoData;
    drive(1'b0, 2'b00, 6'd0, 32'd0, 32'd0);
    step();
  endtask

  task automatic drain();
    logic [31:0] hi, lo;
    exp_t e;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      read_hilo(e.tag, hi, lo);
      check({e.tag, "_hi"}, 64'(hi), 64'(e.hi));
      check({e.tag, "_lo"}, 64'(lo), 64'(e.lo));
    end
  endtask

  task automatic run_op(input string tag, input logic [5:0] fn, input logic [31:0] a,
                        input logic [31:0] b);
    int s;
    issue(tag, fn, a, b, 1'b1, s);
    drain();
  endtask

  logic [11:0] dec_tab[15] = '{
    {2'b00, 6'b000000, 4'b0010}, {2'b00, 6'b111111, 4'b0010},
    {2'b01, 6'b100000, 4'b0110}, {2'b11, 6'b100101, 4'b0000},
    {2'b10, 6'b100000, 4'b0010}, {2'b10, 6'b100010, 4'b0110},
    {2'b10, 6'b100100, 4'b0000}, {2'b10, 6'b100101, 4'b0001},
    {2'b10, 6'b101010, 4'b1111}, {2'b10, 6'b011000, 4'b0000},
    {2'b10, 6'b011001, 4'b0000}, {2'b10, 6'b011010, 4'b0000},
    {2'b10, 6'b010000, 4'b0000}, {2'b10, 6'b010010, 4'b0000},
    {2'b10, 6'b111111, 4'b0000}
  };

  initial begin
    int cnt, s;
    logic [11:0] ent;
    exp_t e;
    logic [31:0] ra, rb;
    logic [5:0]  rf;

    reset = 1'b1;
    drive(1'b0, 2'b00, 6'd0, 32'd0, 32'd0);
    step(); step();
    drive(1'b1, 2'b10, F_MFHI, 32'd0, 32'd0);
    #1;
    check("rst_busy", 64'(Busy), 64'd0);
    check("rst_stall", 64'(Stall), 64'd0);
    check("rst_hilodata", 64'(HiLoData), 64'd0);
    check("rst_hilord", 64'(HiLoRead), 64'd1);
    drive(1'b0, 2'b00, 6'd0, 32'd0, 32'd0);
    reset = 1'b0;
    step();

    // Decode sweep, Valid low so no muldiv launches
    foreach (dec_tab[i]) begin
      ent = dec_tab[i];
      drive(1'b0, ent[11:10], ent[9:4], 32'd0, 32'd0);
      #1;
      check($sformatf("dec_%0d", i), 64'(ALUCtrl), 64'(ent[3:0]));
    end
    drive(1'b0, 2'b10, 6'b100111, 32'd0, 32'd0); #1;
    check("dec_nor", 64'(ALUCtrl), EXT ? 64'hC : 64'h0);
    drive(1'b0, 2'b10, 6'b100110, 32'd0, 32'd0); #1;
    check("dec_xor", 64'(ALUCtrl), EXT ? 64'h3 : 64'h0);
    drive(1'b0, 2'b10, 6'b101011, 32'd0, 32'd0); #1;
    check("dec_sltu", 64'(ALUCtrl), EXT ? 64'h7 : 64'h0);
    drive(1'b0, 2'b10, F_MFLO, 32'd0, 32'd0); #1;
    check("novalid_hilord", 64'(HiLoRead), 64'd0);
    drive(1'b0, 2'b10, F_MULT, 32'd3, 32'd4);
    step(); step();
    check("novalid_nolaunch", 64'(Busy), 64'd0);

    // mult -3*7: no launch stall, Busy for 33 cycles, result readable at cycle 34
    drive(1'b1, 2'b10, F_MULT, 32'hFFFF_FFFD, 32'd7); #1;
    check("launch_stall", 64'(Stall), 64'd0);
    issue("mult_m3x7", F_MULT, 32'hFFFF_FFFD, 32'd7, 1'b1, s);
    cnt = 0;
    while (Busy && cnt < 100) begin
      cnt++;
      step();
    end
    check("busy_cycles", 64'(cnt), 64'd33);
    drain();

    run_op("divu_100_7", F_DIVU, 32'd100, 32'd7);
    run_op("div_m7_2", F_DIV, 32'hFFFF_FFF9, 32'd2);
    run_op("div_5_0", F_DIV, 32'd5, 32'd0);
    run_op("div_m5_0", F_DIV, 32'hFFFF_FFFB, 32'd0);
    run_op("divu_5_0", F_DIVU, 32'd5, 32'd0);
    run_op("div_min_m1", F_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("mult_min_min", F_MULT, 32'h8000_0000, 32'h8000_0000);
    run_op("multu_max", F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("div_m100_m7", F_DIV, 32'hFFFF_FF9C, 32'hFFFF_FFF9);

    // mflo one cycle after launch stalls 33 cycles, then reads the product
    issue("mflo_wait", F_MULT, 32'd12345, 32'hFFFF_FF00, 1'b1, s);
    drive(1'b1, 2'b10, F_MFLO, 32'd0, 32'd0); #1;
    cnt = 0;
    while (Stall && cnt < 100) begin
      cnt++;
      step();
    end
    check("mflo_stall_cycles", 64'(cnt), 64'd33);
    check("mflo_hilord", 64'(HiLoRead), 64'd1);
    e = sb.pop_front();
    check("mflo_data", 64'(HiLoData), 64'(e.lo));
    drive(1'b1, 2'b10, F_MFHI, 32'd0, 32'd0); #1;
    check("mfhi_data", 64'(HiLoData), 64'(e.hi));
    drive(1'b0, 2'b00, 6'd0, 32'd0, 32'd0);
    step();

    // add flows while busy; the later mflo stalls for the remainder
    issue("add_between", F_MULTU, 32'd1000, 32'd999, 1'b1, s);
    drive(1'b1, 2'b10, F_ADD, 32'd1, 32'd2); #1;
    check("add_nostall", 64'(Stall), 64'd0);
    check("add_ctrl", 64'(ALUCtrl), 64'h2);
    check("add_busy", 64'(Busy), 64'd1);
    step();
    drive(1'b1, 2'b10, F_MFLO, 32'd0, 32'd0); #1;
    cnt = 0;
    while (Stall && cnt < 100) begin
      cnt++;
      step();
    end
    check("add_mflo_stall", 64'(cnt), 64'd32);
    drive(1'b0, 2'b00, 6'd0, 32'd0, 32'd0);
    drain();

    // back-to-back: the second op stalls until the first finishes
    issue("first_div", F_DIV, 32'd77, 32'd5, 1'b0, s);
    issue("queued_divu", F_DIVU, 32'd1_000_000, 32'd333, 1'b1, s);
    check("queued_stalls", 64'(s), 64'd33);
    drain();

    // reset mid-RUN after 10 steps aborts the op and clears HI/LO
    issue("aborted", F_MULTU, 32'hDEAD_BEEF, 32'h1234_5678, 1'b0, s);
    repeat (10) step();
    check("pre_rst_busy", 64'(Busy), 64'd1);
    reset = 1'b1; #1;
    check("mid_rst_busy", 64'(Busy), 64'd0);
    drive(1'b1, 2'b10, F_MFHI, 32'd0, 32'd0); #1;
    check("mid_rst_hi", 64'(HiLoData), 64'd0);
    check("mid_rst_stall", 64'(Stall), 64'd0);
    drive(1'b1, 2'b10, F_MFLO, 32'd0, 32'd0); #1;
    check("mid_rst_lo", 64'(HiLoData), 64'd0);
    drive(1'b0, 2'b00, 6'd0, 32'd0, 32'd0);
    step();
    reset = 1'b0;
    step(); step();
    check("post_rst_busy", 64'(Busy), 64'd0);
    run_op("multu_2x3", F_MULTU, 32'd2, 32'd3);

    // random operands across all four ops
    for (int i = 0; i < 8; i++) begin
      ra = $urandom;
      rb = (i % 3 == 0) ? 32'($urandom_range(1, 50)) : $urandom;
      if (i % 2 == 1) rb = -rb;
      rf = {4'b0110, 2'(i % 4)};
      run_op($sformatf("rand_%0d", i), rf, ra, rb);
    end

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
